// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types for the instruction fetch front-end
package fetch_unit_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic [31:0] pc_4;
    } INSTRUCTION_FECHED;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } FETCH_STATE;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous first-word-fall-through FIFO with flush
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential PC fetch with buffered output; FETCH_STATS_EN adds drop/fetch counters
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jump,
    input  logic [31:0]       jump_pc,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output INSTRUCTION_FECHED instruction_o,
    output logic              valid_o,
    input  logic              ready_o
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_dropped
`endif
);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = ((OW > FW) ? OW : FW) + 1;

    FETCH_STATE        state_q;
    FETCH_STATE        state_d;
    logic [31:0]       pc_q;
    logic [OW-1:0]     discard_q;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     outstanding_next;
    logic [FW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              aq_full;
    logic              aq_empty;
    logic [31:0]       resp_addr;
    logic [CW-1:0]     credit_used;
    logic              credit_ok;
    logic              accept;
    logic              resp_valid;
    logic              drop_resp;
    logic              push;
    logic              pop;
    INSTRUCTION_FECHED push_word;

    // Every issued request reserves a buffer slot, so the buffer can never overflow.
    assign credit_used = CW'(fifo_count) + CW'(outstanding);
    assign credit_ok   = credit_used < CW'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= BOOT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                state_d  = RUN;
                imem_req = credit_ok && !aq_full && !fifo_full;
            end
            default: state_d = BOOT;
        endcase
    end

    assign imem_addr  = pc_q;
    assign accept     = imem_req && imem_ready;
    assign resp_valid = imem_rvalid && !aq_empty;
    assign drop_resp  = resp_valid && (jump || (discard_q != '0));
    assign push       = resp_valid && !drop_resp;
    assign pop        = valid_o && ready_o;
    assign valid_o    = !fifo_empty;

    assign outstanding_next = outstanding + OW'(accept) - OW'(resp_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else if (jump) begin
            pc_q      <= jump_pc;
            discard_q <= outstanding_next;
        end else begin
            if (accept) pc_q <= pc_q + INSTR_BYTES;
            if (resp_valid && (discard_q != '0)) discard_q <= discard_q - OW'(1);
        end
    end

    // Address queue doubles as the outstanding-request counter.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_addr_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (pc_q),
        .pop       (resp_valid),
        .flush     (1'b0),
        .pop_data  (resp_addr),
        .full      (aq_full),
        .empty     (aq_empty),
        .count     (outstanding)
    );

    assign push_word.instruction = imem_rdata;
    assign push_word.pc          = resp_addr;
    assign push_word.pc_4        = resp_addr + INSTR_BYTES;

    fetch_fifo #(
        .WIDTH ($bits(INSTRUCTION_FECHED)),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .flush     (jump),
        .pop_data  (instruction_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assert property (@(posedge clk) disable iff (!reset) imem_rvalid |-> !aq_empty);

`ifdef FETCH_STATS_EN
    logic [FW-1:0] flushed;
    logic [32:0]   fetched_sum;
    logic [32:0]   dropped_sum;

    // Entries handed to decode in the jump cycle are fetched, not flushed.
    assign flushed     = jump ? (fifo_count - FW'(pop)) : '0;
    assign fetched_sum = {1'b0, stat_fetched} + 33'(pop);
    assign dropped_sum = {1'b0, stat_dropped} + 33'(flushed) + 33'(drop_resp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_fetched <= '0;
            stat_dropped <= '0;
        end else begin
            stat_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
            stat_dropped <= dropped_sum[32] ? '1 : dropped_sum[31:0];
        end
    end
`endif

endmodule
